// File: rtl/uart_tx.sv
// uart_tx: valid/ready fed asynchronous serial transmitter.
// Frame is start bit, LSB-first data, optional parity, 1 or 2 stops.
module uart_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done
);
    localparam int T        = CLK_FREQ / BAUD_RATE;
    localparam int STOP_LEN = STOP_BITS * T;
    localparam int CW       = $clog2(STOP_LEN + 1);
    localparam int IW       = $clog2(DATA_WIDTH + 1);

    localparam logic [CW-1:0] BIT_END  = CW'(T - 1);
    localparam logic [CW-1:0] STOP_END = CW'(STOP_LEN - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_WIDTH - 1);
    localparam logic          ODD      = (PARITY == 2);

    generate
        if (T < 2) begin : g_bad_baud
            $error("uart_tx: CLK_FREQ/BAUD_RATE must be >= 2");
        end
        if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_width
            $error("uart_tx: DATA_WIDTH must be 5..9");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
            $error("uart_tx: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
            $error("uart_tx: STOP_BITS must be 1 or 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                state, state_n;
    logic [CW-1:0]         cnt, cnt_n;
    logic [IW-1:0]         idx, idx_n;
    logic [DATA_WIDTH-1:0] shreg, sh_n;
    logic                  par, par_n;
    logic                  tx_n, rdy_n, busy_n, done_n;
    logic                  bit_end;

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        sh_n    = shreg;
        par_n   = par;
        tx_n    = tx;
        rdy_n   = tx_ready;
        busy_n  = busy;
        done_n  = 1'b0;
        bit_end = (cnt == BIT_END);
        unique case (state)
            S_IDLE: begin
                if (tx_valid && tx_ready) begin
                    sh_n    = tx_data;
                    par_n   = (^tx_data) ^ ODD;
                    state_n = S_START;
                    tx_n    = 1'b0;
                    rdy_n   = 1'b0;
                    busy_n  = 1'b1;
                    cnt_n   = '0;
                    idx_n   = '0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    cnt_n   = '0;
                    tx_n    = shreg[0];
                    sh_n    = shreg >> 1;
                    state_n = S_DATA;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_DATA: begin
                if (!bit_end) begin
                    cnt_n = cnt + CW'(1);
                end else if (idx != LAST_IDX) begin
                    cnt_n = '0;
                    idx_n = idx + IW'(1);
                    tx_n  = shreg[0];
                    sh_n  = shreg >> 1;
                end else if (PARITY != 0) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    tx_n    = par;
                    state_n = S_PARITY;
                end else begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    tx_n    = 1'b1;
                    state_n = S_STOP;
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    cnt_n   = '0;
                    tx_n    = 1'b1;
                    state_n = S_STOP;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_STOP: begin
                if (cnt == STOP_END) begin
                    cnt_n   = '0;
                    state_n = S_IDLE;
                    rdy_n   = 1'b1;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
                tx_n    = 1'b1;
                rdy_n   = 1'b1;
                busy_n  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            idx      <= '0;
            shreg    <= '0;
            par      <= 1'b0;
            tx       <= 1'b1;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            idx      <= idx_n;
            shreg    <= sh_n;
            par      <= par_n;
            tx       <= tx_n;
            tx_ready <= rdy_n;
            busy     <= busy_n;
            tx_done  <= done_n;
        end
    end
endmodule
